// File: rtl/cpu_defs.sv
// cpu_defs: shared opcode/funct constants, FSM states and datapath mux encodings
package cpu_defs;
  typedef enum logic [2:0] {
    S_IF = 3'd0, S_ID = 3'd1, S_EXE = 3'd2, S_MEM = 3'd3, S_WB = 3'd4, S_HALT = 3'd5, S_TRAP = 3'd6
  } state_e;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BLTZ  = 6'b000001;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_HALT  = 6'b111111;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [1:0] PC_NEXT = 2'b00, PC_BRANCH = 2'b01, PC_JR = 2'b10, PC_JUMP = 2'b11;
  localparam logic [1:0] RD_RT = 2'b00, RD_RD = 2'b01, RD_RA = 2'b10;
  localparam logic [1:0] WD_ALU = 2'b00, WD_RAM = 2'b01, WD_PC4 = 2'b10;
  typedef enum logic [3:0] {
    CL_BAD, CL_J, CL_JAL, CL_JR, CL_HALT, CL_BEQ, CL_BNE, CL_BLTZ, CL_LW, CL_SW, CL_ALUI, CL_ALUR
  } iclass_e;
endpackage

// File: rtl/cu_decode.sv
// cu_decode: classifies an instruction and derives its ALU control fields
module cu_decode
  import cpu_defs::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output iclass_e    cls_o,
  output logic       legal_o,
  output logic [2:0] alu_op_o,
  output logic       alu_src_a_o,
  output logic       alu_src_b_o,
  output logic       ext_sel_o
);
  assign legal_o = cls_o != CL_BAD;
  // instruction table: anything not listed stays CL_BAD
  always_comb begin
    cls_o = CL_BAD;
    alu_op_o = ALU_ADD;
    alu_src_a_o = 1'b0;
    alu_src_b_o = 1'b0;
    ext_sel_o = 1'b0;
    case (opcode_i)
      OP_RTYPE: case (funct_i)
        FN_ADD: cls_o = CL_ALUR;
        FN_SUB: begin cls_o = CL_ALUR; alu_op_o = ALU_SUB; end
        FN_AND: begin cls_o = CL_ALUR; alu_op_o = ALU_AND; end
        FN_OR:  begin cls_o = CL_ALUR; alu_op_o = ALU_OR; end
        FN_SLT: begin cls_o = CL_ALUR; alu_op_o = ALU_SLT; end
        FN_SLL: begin cls_o = CL_ALUR; alu_op_o = ALU_SLL; alu_src_a_o = 1'b1; end
        FN_JR:  cls_o = CL_JR;
        default: cls_o = CL_BAD;
      endcase
      OP_J:     cls_o = CL_J;
      OP_JAL:   cls_o = CL_JAL;
      OP_HALT:  cls_o = CL_HALT;
      OP_BEQ:   begin cls_o = CL_BEQ; alu_op_o = ALU_SUB; ext_sel_o = 1'b1; end
      OP_BNE:   begin cls_o = CL_BNE; alu_op_o = ALU_SUB; ext_sel_o = 1'b1; end
      OP_BLTZ:  begin cls_o = CL_BLTZ; alu_op_o = ALU_SUB; ext_sel_o = 1'b1; end
      OP_LW:    begin cls_o = CL_LW; alu_src_b_o = 1'b1; ext_sel_o = 1'b1; end
      OP_SW:    begin cls_o = CL_SW; alu_src_b_o = 1'b1; ext_sel_o = 1'b1; end
      OP_ADDIU: begin cls_o = CL_ALUI; alu_src_b_o = 1'b1; ext_sel_o = 1'b1; end
      OP_ANDI:  begin cls_o = CL_ALUI; alu_op_o = ALU_AND; alu_src_b_o = 1'b1; end
      OP_ORI:   begin cls_o = CL_ALUI; alu_op_o = ALU_OR; alu_src_b_o = 1'b1; end
      OP_SLTI:  begin cls_o = CL_ALUI; alu_op_o = ALU_SLT; alu_src_b_o = 1'b1; ext_sel_o = 1'b1; end
      default:  cls_o = CL_BAD;
    endcase
  end
endmodule

// File: rtl/multi_cycle_cu.sv
// multi_cycle_cu: five-phase MIPS control FSM with RAM handshake, timeout trap and retire counter
module multi_cycle_cu
  import cpu_defs::*;
#(
  parameter int ALUOP_W     = 3,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [5:0]         Opcode,
  input  logic [5:0]         Funct,
  input  logic               Zero,
  input  logic               Sign,
  input  logic               MemReady,
  output logic               PCWre,
  output logic               IRWre,
  output logic               RegWre,
  output logic [1:0]         RegDst,
  output logic [1:0]         WrDataSrc,
  output logic               ALUSrcA,
  output logic               ALUSrcB,
  output logic               ExtSel,
  output logic               nRD,
  output logic               nWR,
  output logic [1:0]         PCSrc,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [2:0]         State,
  output logic               Halted,
  output logic               Fault,
  output logic [CNT_W-1:0]   Retired
);
  localparam int WAIT_W = MEM_TIMEOUT < 2 ? 1 : $clog2(MEM_TIMEOUT + 1);
  state_e state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0] retired_q;
  iclass_e cls;
  logic legal, alu_src_a, alu_src_b, ext_sel;
  logic [2:0] alu_op;
  logic in_id, in_exe, in_mem, in_wb, alu_act, is_jump, is_branch, is_mem, taken, timeout;
  cu_decode u_decode (
    .opcode_i    (Opcode),
    .funct_i     (Funct),
    .cls_o       (cls),
    .legal_o     (legal),
    .alu_op_o    (alu_op),
    .alu_src_a_o (alu_src_a),
    .alu_src_b_o (alu_src_b),
    .ext_sel_o   (ext_sel)
  );
  assign in_id = state_q == S_ID;
  assign in_exe = state_q == S_EXE;
  assign in_mem = state_q == S_MEM;
  assign in_wb = state_q == S_WB;
  assign alu_act = in_exe | in_mem | in_wb;
  assign is_jump = cls inside {CL_J, CL_JAL, CL_JR};
  assign is_branch = cls inside {CL_BEQ, CL_BNE, CL_BLTZ};
  assign is_mem = cls inside {CL_LW, CL_SW};
  assign taken = cls == CL_BEQ ? Zero : cls == CL_BNE ? !Zero : Sign;
  assign timeout = MEM_TIMEOUT != 0 && ({1'b0, wait_q} + 1'b1) == (WAIT_W + 1)'(MEM_TIMEOUT);
  assign PCWre = (in_id & is_jump) | (in_exe & is_branch) | (in_mem & MemReady & (cls == CL_SW)) | in_wb;
  assign IRWre = state_q == S_IF;
  assign RegWre = (in_id & (cls == CL_JAL)) | in_wb;
  assign RegDst = in_id && cls == CL_JAL ? RD_RA : in_wb && cls == CL_ALUR ? RD_RD : RD_RT;
  assign WrDataSrc = in_id && cls == CL_JAL ? WD_PC4 : in_wb && cls == CL_LW ? WD_RAM : WD_ALU;
  assign PCSrc = in_id && (cls inside {CL_J, CL_JAL}) ? PC_JUMP :
                 in_id && cls == CL_JR ? PC_JR :
                 in_exe && is_branch && taken ? PC_BRANCH : PC_NEXT;
  assign ALUSrcA = alu_act & alu_src_a;
  assign ALUSrcB = alu_act & alu_src_b;
  assign ExtSel = alu_act & ext_sel;
  assign ALUOp = alu_act ? ALUOP_W'(alu_op) : '0;
  assign nRD = !(in_mem && cls == CL_LW);
  assign nWR = !(in_mem && cls == CL_SW);
  assign State = state_q;
  assign Halted = state_q == S_HALT;
  assign Fault = state_q == S_TRAP;
  assign Retired = retired_q;
  // next-state and stall counter; HALT and TRAP hold until reset
  always_comb begin
    state_d = state_q;
    wait_d = wait_q;
    case (state_q)
      S_IF:  state_d = S_ID;
      S_ID:  state_d = !legal ? S_TRAP : cls == CL_HALT ? S_HALT : is_jump ? S_IF : S_EXE;
      S_EXE: begin
        state_d = is_mem ? S_MEM : is_branch ? S_IF : S_WB;
        wait_d = '0;
      end
      S_MEM: begin
        state_d = MemReady ? (cls == CL_LW ? S_WB : S_IF) : timeout ? S_TRAP : S_MEM;
        wait_d = wait_q + 1'b1;
      end
      S_WB:  state_d = S_IF;
      default: state_d = state_q;
    endcase
  end
  // state, stall counter and retire counter; retire counts each PC update
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IF;
      wait_q <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q <= wait_d;
      retired_q <= retired_q + CNT_W'(PCWre);
    end
  end
endmodule

// File: tb/tb_multi_cycle_cu.sv
// tb_multi_cycle_cu: random instruction stream checked cycle by cycle against a per-instruction timeline model
module tb_multi_cycle_cu;
  localparam int TMO = 16;
  localparam int K_BAD = 0, K_J = 1, K_JAL = 2, K_JR = 3, K_HALT = 4, K_BEQ = 5, K_BNE = 6,
                 K_BLTZ = 7, K_LW = 8, K_SW = 9, K_I = 10, K_R = 11;
  logic CLK = 1'b0, Reset = 1'b0, Zero = 1'b0, Sign = 1'b0, MemReady = 1'b0;
  logic [5:0] Opcode = '0, Funct = '0;
  logic PCWre, IRWre, RegWre, ALUSrcA, ALUSrcB, ExtSel, nRD, nWR, Halted, Fault;
  logic [1:0] RegDst, WrDataSrc, PCSrc;
  logic [2:0] ALUOp, State;
  logic [31:0] Retired;
  typedef struct packed {
    logic [2:0] st;
    logic pcw, irw, rgw;
    logic [1:0] rdst, wds;
    logic sa, sb, ext, nrd, nwr;
    logic [1:0] pcs;
    logic [2:0] aop;
    logic hlt, flt;
    logic [31:0] ret;
  } obs_t;
  int checks = 0, failures = 0, ncyc = 0, nrd_low = 0, dead = 0;
  logic [31:0] ret_m = '0;
  obs_t last_pcw;
  logic [11:0] pool [17] = '{
    {6'b001001, 6'd0}, {6'b001100, 6'd0}, {6'b001101, 6'd0}, {6'b001010, 6'd0},
    {6'b000000, 6'b100000}, {6'b000000, 6'b100010}, {6'b000000, 6'b100100},
    {6'b000000, 6'b100101}, {6'b000000, 6'b101010}, {6'b000000, 6'b000000},
    {6'b000000, 6'b001000}, {6'b000010, 6'd0}, {6'b000011, 6'd0},
    {6'b000100, 6'd0}, {6'b000101, 6'd0}, {6'b000001, 6'd0}, {6'b100011, 6'd0}
  };
  multi_cycle_cu #(.ALUOP_W(3), .MEM_TIMEOUT(TMO), .CNT_W(32)) dut (
    .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero), .Sign(Sign),
    .MemReady(MemReady), .PCWre(PCWre), .IRWre(IRWre), .RegWre(RegWre), .RegDst(RegDst),
    .WrDataSrc(WrDataSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ExtSel(ExtSel), .nRD(nRD),
    .nWR(nWR), .PCSrc(PCSrc), .ALUOp(ALUOp), .State(State), .Halted(Halted), .Fault(Fault),
    .Retired(Retired)
  );
  always #5 CLK = ~CLK;
  function automatic obs_t obs();
    return {State, PCWre, IRWre, RegWre, RegDst, WrDataSrc, ALUSrcA, ALUSrcB, ExtSel, nRD, nWR,
            PCSrc, ALUOp, Halted, Fault, Retired};
  endfunction
  function automatic obs_t idle();
    obs_t e = '0;
    e.nrd = 1'b1;
    e.nwr = 1'b1;
    e.ret = ret_m;
    return e;
  endfunction
  task automatic chk(input string name, input longint a, input longint e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, a, e);
    end
  endtask
  task automatic cyc(input obs_t e, input logic mr, input string tag);
    obs_t a;
    MemReady = mr;
    @(negedge CLK);
    a = obs();
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (st,pcw,irw,rgw,rdst,wds,sa,sb,ext,nrd,nwr,pcs,aop,hlt,flt,ret)", tag, a, e);
    end
    if (!nRD) nrd_low++;
    if (PCWre) last_pcw = a;
    ncyc++;
    @(posedge CLK);
    #1;
  endtask
  task automatic tb_decode(input logic [5:0] op, input logic [5:0] fn, output int k,
                           output logic [2:0] aop, output logic sa, output logic sb, output logic ext);
    k = K_BAD; aop = 3'b000; sa = 0; sb = 0; ext = 0;
    case (op)
      6'b000000: case (fn)
        6'b100000: k = K_R;
        6'b100010: begin k = K_R; aop = 3'b001; end
        6'b100100: begin k = K_R; aop = 3'b100; end
        6'b100101: begin k = K_R; aop = 3'b011; end
        6'b101010: begin k = K_R; aop = 3'b101; end
        6'b000000: begin k = K_R; aop = 3'b010; sa = 1; end
        6'b001000: k = K_JR;
        default: k = K_BAD;
      endcase
      6'b000010: k = K_J;
      6'b000011: k = K_JAL;
      6'b111111: k = K_HALT;
      6'b000100: begin k = K_BEQ; aop = 3'b001; ext = 1; end
      6'b000101: begin k = K_BNE; aop = 3'b001; ext = 1; end
      6'b000001: begin k = K_BLTZ; aop = 3'b001; ext = 1; end
      6'b100011: begin k = K_LW; sb = 1; ext = 1; end
      6'b101011: begin k = K_SW; sb = 1; ext = 1; end
      6'b001001: begin k = K_I; sb = 1; ext = 1; end
      6'b001100: begin k = K_I; aop = 3'b100; sb = 1; end
      6'b001101: begin k = K_I; aop = 3'b011; sb = 1; end
      6'b001010: begin k = K_I; aop = 3'b101; sb = 1; ext = 1; end
      default: k = K_BAD;
    endcase
  endtask
  task automatic do_reset();
    obs_t e = '0;
    Reset = 1'b0;
    MemReady = 1'b1;
    #3;
    ret_m = '0;
    dead = 0;
    e.irw = 1'b1; e.nrd = 1'b1; e.nwr = 1'b1;
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL reset got=%h exp=%h", obs(), e);
    end
    @(posedge CLK);
    #1;
    Reset = 1'b1;
  endtask
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic s,
                           input int rdy, input int abort_k);
    obs_t e;
    int k;
    logic [2:0] aop;
    logic sa, sb, ext, tk;
    ncyc = 0; nrd_low = 0;
    Opcode = op; Funct = fn; Zero = z; Sign = s;
    e = idle();
    if (dead != 0) begin
      e.st = dead == 1 ? 3'd5 : 3'd6;
      e.hlt = dead == 1;
      e.flt = dead == 2;
      cyc(e, 1'($urandom), "dead");
      return;
    end
    e.st = 3'd0; e.irw = 1'b1;
    cyc(e, 1'($urandom), "IF");
    tb_decode(op, fn, k, aop, sa, sb, ext);
    e = idle(); e.st = 3'd1;
    if (k == K_BAD || k == K_HALT) begin
      cyc(e, 1'($urandom), "ID");
      dead = k == K_HALT ? 1 : 2;
      return;
    end
    if (k == K_J || k == K_JAL || k == K_JR) begin
      e.pcw = 1'b1;
      e.pcs = k == K_JR ? 2'b10 : 2'b11;
      if (k == K_JAL) begin e.rgw = 1'b1; e.rdst = 2'b10; e.wds = 2'b10; end
      cyc(e, 1'($urandom), "ID_jump");
      ret_m++;
      return;
    end
    cyc(e, 1'($urandom), "ID");
    e = idle(); e.st = 3'd2; e.sa = sa; e.sb = sb; e.ext = ext; e.aop = aop;
    if (k == K_BEQ || k == K_BNE || k == K_BLTZ) begin
      tk = k == K_BEQ ? z : k == K_BNE ? !z : s;
      e.pcw = 1'b1;
      e.pcs = tk ? 2'b01 : 2'b00;
      cyc(e, 1'($urandom), "EXE_branch");
      ret_m++;
      return;
    end
    cyc(e, 1'($urandom), "EXE");
    if (k == K_LW || k == K_SW) begin
      for (int m = 0; m < TMO; m++) begin
        e.st = 3'd3;
        e.nrd = k != K_LW;
        e.nwr = k != K_SW;
        if (m == abort_k) begin
          MemReady = 1'b0;
          @(negedge CLK);
          chk("abort_pre_nrd", longint'(nRD), 0);
          Reset = 1'b0;
          #1;
          chk("abort_state", longint'(State), 0);
          chk("abort_retired", longint'(Retired), 0);
          chk("abort_nrd", longint'(nRD), 1);
          ret_m = '0;
          dead = 0;
          @(posedge CLK);
          #1;
          Reset = 1'b1;
          return;
        end
        e.pcw = (m == rdy) && k == K_SW;
        cyc(e, m == rdy, "MEM");
        if (m == rdy) begin
          if (k == K_SW) begin ret_m++; return; end
          break;
        end
        if (m == TMO - 1) begin dead = 2; return; end
      end
    end
    e = idle(); e.st = 3'd4; e.sa = sa; e.sb = sb; e.ext = ext; e.aop = aop;
    e.rgw = 1'b1; e.pcw = 1'b1;
    e.rdst = k == K_R ? 2'b01 : 2'b00;
    e.wds = k == K_LW ? 2'b01 : 2'b00;
    cyc(e, 1'($urandom), "WB");
    ret_m++;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] r0;
    do_reset();
    run_instr(6'b001001, 6'd0, 0, 0, 0, -1);
    chk("addiu_cycles", ncyc, 4);
    chk("addiu_retired", longint'(Retired), 1);
    chk("addiu_wb_state", longint'(last_pcw.st), 4);
    run_instr(6'b100011, 6'd0, 0, 0, 3, -1);
    chk("lw_cycles", ncyc, 8);
    chk("lw_nrd_low", nrd_low, 4);
    chk("lw_wds", longint'(last_pcw.wds), 1);
    run_instr(6'b000100, 6'd0, 1, 0, 0, -1);
    chk("beq_pcsrc", longint'(last_pcw.pcs), 1);
    chk("beq_cycles", ncyc, 3);
    run_instr(6'b000101, 6'd0, 1, 0, 0, -1);
    chk("bne_pcsrc", longint'(last_pcw.pcs), 0);
    run_instr(6'b000001, 6'd0, 0, 1, 0, -1);
    chk("bltz_pcsrc", longint'(last_pcw.pcs), 1);
    run_instr(6'b000011, 6'd0, 0, 0, 0, -1);
    chk("jal_cycles", ncyc, 2);
    chk("jal_fields", longint'({last_pcw.rdst, last_pcw.wds, last_pcw.pcs}), 6'b101011);
    run_instr(6'b000000, 6'b001000, 0, 0, 0, -1);
    chk("jr_pcsrc", longint'(last_pcw.pcs), 2);
    chk("jr_cycles", ncyc, 2);
    r0 = Retired;
    chk("retired_before_sw", longint'(r0), 7);
    run_instr(6'b101011, 6'd0, 0, 0, TMO, -1);
    chk("sw_timeout_cycles", ncyc, 3 + TMO);
    for (int i = 0; i < 3; i++) run_instr(6'b001001, 6'd0, 0, 0, 0, -1);
    chk("trap_fault", longint'(Fault), 1);
    chk("trap_nwr", longint'(nWR), 1);
    chk("trap_retired", longint'(Retired), longint'(r0));
    do_reset();
    run_instr(6'b111111, 6'd0, 0, 0, 0, -1);
    for (int i = 0; i < 100; i++) run_instr(6'(($urandom)), 6'($urandom), 0, 0, 0, -1);
    chk("halt_held", longint'(Halted), 1);
    do_reset();
    run_instr(6'b001101, 6'd0, 0, 0, 0, -1);
    run_instr(6'b100011, 6'd0, 0, 0, 5, 2);
    run_instr(6'b001001, 6'd0, 0, 0, 0, -1);
    chk("after_abort_retired", longint'(Retired), 1);
    for (int i = 0; i < 400; i++) begin
      logic [11:0] p;
      logic [5:0] op, fn;
      int rdy;
      p = pool[$urandom_range(0, 16)];
      op = p[11:6];
      fn = p[5:0];
      if ($urandom_range(0, 9) == 0) op = 6'b101011;
      if ($urandom_range(0, 39) == 0) begin op = 6'($urandom); fn = 6'($urandom); end
      rdy = $urandom_range(0, 19) == 0 ? TMO : $urandom_range(0, 5);
      run_instr(op, fn, 1'($urandom), 1'($urandom), rdy, -1);
      if (dead != 0) begin
        for (int j = 0; j < 3; j++) run_instr(6'($urandom), 6'($urandom), 0, 0, 0, -1);
        do_reset();
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
